// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared types and latency helpers for the FP issue/writeback block
//
// Purpose: op and unit-select enums, the reservation slot record, and the
// latency function used by both the scheduler and the top.
// Ports: none (package).

package fpu_pkg;

  // Tag width carried in a slot. The top's TAG_W parameter must match it.
  localparam int FPU_TAG_W = 5;

  localparam int UL_ADDSUB_DEF = 2;
  localparam int UL_MUL_DEF    = 1;

  typedef enum logic [1:0] {
    OP_FADD = 2'b00,
    OP_FSUB = 2'b01,
    OP_FMUL = 2'b10,
    OP_FNEG = 2'b11
  } fpu_op_e;

  typedef enum logic [1:0] {
    UNIT_ADD = 2'b00,
    UNIT_SUB = 2'b01,
    UNIT_MUL = 2'b10,
    UNIT_NEG = 2'b11
  } fpu_unit_e;

  typedef struct packed {
    logic                 valid;
    logic [FPU_TAG_W-1:0] tag;
    fpu_unit_e            sel;
  } fpu_slot_t;

  // Accept-to-wb_valid latency: unit latency plus the operand register and
  // the writeback register. FNEG has no unit, only those two registers.
  function automatic int op_latency(fpu_op_e op, int ul_addsub, int ul_mul);
    int lat;
    case (op)
      OP_FADD, OP_FSUB: lat = ul_addsub + 2;
      OP_FMUL:          lat = ul_mul + 2;
      default:          lat = 2;
    endcase
    return lat;
  endfunction

  function automatic fpu_unit_e op_unit(fpu_op_e op);
    fpu_unit_e u;
    case (op)
      OP_FADD: u = UNIT_ADD;
      OP_FSUB: u = UNIT_SUB;
      OP_FMUL: u = UNIT_MUL;
      default: u = UNIT_NEG;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/fpu_wb_sched.sv
// rtl/fpu_wb_sched.sv - writeback slot reservation shift register
//
// Purpose: s[k] valid means the result leaves the writeback register k+1
// cycles from now (wb_valid rises k cycles after this cycle's edge). An
// accepted op of latency L is written into s[L-1]; it collides only if s[L]
// is occupied now, since that entry shifts into s[L-1] at the same edge.
// Ports:
//   clk, rstn     clock, async active-low reset
//   flush         clear every slot at the edge
//   accept        write the op described by op/tag this edge
//   op, tag       op being offered (free is combinational on op)
//   free          the writeback slot for op is unreserved
//   head          s[1], the slot reaching writeback next edge
//   any_valid     any slot occupied

module fpu_wb_sched
  import fpu_pkg::*;
#(
  parameter int UL_ADDSUB = UL_ADDSUB_DEF,
  parameter int UL_MUL    = UL_MUL_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic                 accept,
  input  fpu_op_e              op,
  input  logic [FPU_TAG_W-1:0] tag,
  output logic                 free,
  output fpu_slot_t            head,
  output logic                 any_valid
);

  localparam int D = UL_ADDSUB + 1;

  fpu_slot_t s [1:D];
  fpu_slot_t new_slot;
  int        lat;

  always_comb begin
    lat            = op_latency(op, UL_ADDSUB, UL_MUL);
    new_slot.valid = 1'b1;
    new_slot.tag   = tag;
    new_slot.sel   = op_unit(op);
  end

  // Max-latency ops (lat == D+1) match no k and are therefore never blocked.
  always_comb begin
    free      = 1'b1;
    any_valid = 1'b0;
    for (int k = 1; k <= D; k++) begin
      if (k == lat && s[k].valid) free = 1'b0;
      any_valid = any_valid | s[k].valid;
    end
  end

  assign head = s[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 1; k <= D; k++) s[k] <= '0;
    end else if (flush) begin
      for (int k = 1; k <= D; k++) s[k] <= '0;
    end else begin
      for (int k = 1; k <= D; k++) begin
        if (accept && k == lat - 1) s[k] <= new_slot;
        else if (k < D)             s[k] <= s[k+1];
        else                        s[k] <= '0;
      end
    end
  end

endmodule

// File: rtl/fpu_issue_wb.sv
// rtl/fpu_issue_wb.sv - issue/writeback front end for pipelined fadd/fsub/fmul units
//
// Purpose: accepts tagged FP ops, drives a shared registered operand bus to
// free-running units, reserves the single writeback slot at issue and
// returns tagged results (possibly out of order). FNEG is done here.
// Ports:
//   clk, rstn                  clock, async active-low reset
//   in_valid/in_ready          op handshake; in_ready depends on in_op only
//   in_op, in_tag, in_x1/x2    op, destination tag, operands
//   flush                      discard all in-flight ops
//   u_x1, u_x2                 shared operand bus to all units
//   u_add_y/u_sub_y/u_mul_y    unit results
//   wb_valid/wb_tag/wb_data    single-cycle tagged result, no backpressure
//   busy                       any op in flight

module fpu_issue_wb
  import fpu_pkg::*;
#(
  parameter int TAG_W     = FPU_TAG_W,
  parameter int UL_ADDSUB = UL_ADDSUB_DEF,
  parameter int UL_MUL    = UL_MUL_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic             flush,
  output logic [31:0]      u_x1,
  output logic [31:0]      u_x2,
  input  logic [31:0]      u_add_y,
  input  logic [31:0]      u_sub_y,
  input  logic [31:0]      u_mul_y,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  output logic [31:0]      wb_data,
  output logic             busy
);

  fpu_op_e   op;
  logic      slot_free;
  logic      accept;
  logic      any_valid;
  fpu_slot_t head;
  logic [31:0] res;

  assign op       = fpu_op_e'(in_op);
  assign in_ready = rstn && !flush && slot_free;
  assign accept   = in_valid && in_ready;

  fpu_wb_sched #(
    .UL_ADDSUB (UL_ADDSUB),
    .UL_MUL    (UL_MUL)
  ) u_sched (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .accept    (accept),
    .op        (op),
    .tag       (in_tag),
    .free      (slot_free),
    .head      (head),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      u_x1 <= '0;
      u_x2 <= '0;
    end else if (accept) begin
      u_x1 <= in_x1;
      u_x2 <= in_x2;
    end
  end

  // FNEG's slot reaches s[1] the cycle its operand sits on u_x1, so the
  // sign flip reads the bus directly.
  always_comb begin
    res = u_add_y;
    case (head.sel)
      UNIT_ADD: res = u_add_y;
      UNIT_SUB: res = u_sub_y;
      UNIT_MUL: res = u_mul_y;
      default:  res = {~u_x1[31], u_x1[30:0]};
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_valid <= 1'b0;
      wb_tag   <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= head.valid && !flush;
      if (head.valid && !flush) begin
        wb_tag  <= head.tag;
        wb_data <= res;
      end
    end
  end

  assign busy = any_valid | wb_valid;

endmodule

// File: tb/tb_fpu_issue_wb.sv
// tb/tb_fpu_issue_wb.sv - directed self-checking bench for fpu_issue_wb

module tb_fpu_issue_wb;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [4:0]  in_tag;
  logic [31:0] in_x1, in_x2;
  logic        flush;
  logic [31:0] u_x1, u_x2;
  logic [31:0] u_add_y, u_sub_y, u_mul_y;
  logic        wb_valid;
  logic [4:0]  wb_tag;
  logic [31:0] wb_data;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fpu_issue_wb dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_tag(in_tag), .in_x1(in_x1), .in_x2(in_x2),
    .flush(flush), .u_x1(u_x1), .u_x2(u_x2),
    .u_add_y(u_add_y), .u_sub_y(u_sub_y), .u_mul_y(u_mul_y),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .busy(busy)
  );

  // Behavioural FP units for normal numbers and zero (exact for the vectors used).
  function automatic real s2r(logic [31:0] b);
    real m;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2s(real r);
    logic [63:0] d;
    int e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  logic [31:0] add_r, sub_r;
  always @(posedge clk) begin
    add_r   <= r2s(s2r(u_x1) + s2r(u_x2));
    sub_r   <= r2s(s2r(u_x1) - s2r(u_x2));
    u_add_y <= add_r;
    u_sub_y <= sub_r;
    u_mul_y <= r2s(s2r(u_x1) * s2r(u_x2));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [4:0] tag,
                       input logic [31:0] x1, input logic [31:0] x2);
    in_valid = 1'b1; in_op = op; in_tag = tag; in_x1 = x1; in_x2 = x2;
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_tag = '0;
    in_x1 = '0; in_x2 = '0; flush = 1'b0;
    #2;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    n_cmp++; if (wb_tag !== 5'd0 || wb_data !== 32'd0) begin n_err++; $display("FAIL reset_wb: got %h/%h want 0/0", wb_tag, wb_data); end
    n_cmp++; if (u_x1 !== 32'd0 || u_x2 !== 32'd0) begin n_err++; $display("FAIL reset_ux: got %h/%h want 0/0", u_x1, u_x2); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_fsub();
    drive(2'b01, 5'd3, 32'h40400000, 32'h3F800000);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fsub_ready: got %b want 1", in_ready); end
    step(); idle();
    step(); step();
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL fsub_early: got %b want 0", wb_valid); end
    step();
    n_cmp++; if (wb_valid !== 1'b1 || wb_tag !== 5'd3 || wb_data !== 32'h40000000) begin
      n_err++; $display("FAIL fsub_wb: got %b/%0d/%h want 1/3/40000000", wb_valid, wb_tag, wb_data); end
    step();
    n_cmp++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL fsub_done: got v%b busy%b want 0/0", wb_valid, busy); end
  endtask

  task automatic test_collision();
    drive(2'b00, 5'd4, 32'h3F800000, 32'h40000000);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL coll_fadd_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0; in_op = 2'b00; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL coll_maxlat_ready: got %b want 1", in_ready); end
    drive(2'b10, 5'd5, 32'h40000000, 32'h40400000);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL coll_fmul_blocked: got %b want 0", in_ready); end
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL coll_fmul_ready: got %b want 1", in_ready); end
    step(); idle();
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL coll_early: got %b want 0", wb_valid); end
    step();
    n_cmp++; if (wb_valid !== 1'b1 || wb_tag !== 5'd4 || wb_data !== 32'h40400000) begin
      n_err++; $display("FAIL coll_fadd_wb: got %b/%0d/%h want 1/4/40400000", wb_valid, wb_tag, wb_data); end
    step();
    n_cmp++; if (wb_valid !== 1'b1 || wb_tag !== 5'd5 || wb_data !== 32'h40C00000) begin
      n_err++; $display("FAIL coll_fmul_wb: got %b/%0d/%h want 1/5/40c00000", wb_valid, wb_tag, wb_data); end
    step();
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL coll_done: got %b want 0", wb_valid); end
  endtask

  task automatic test_out_of_order();
    drive(2'b00, 5'd1, 32'h3F800000, 32'h3F800000);
    step();
    drive(2'b11, 5'd2, 32'h3F800000, 32'h00000000);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ooo_fneg_ready: got %b want 1", in_ready); end
    step(); idle();
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL ooo_early: got %b want 0", wb_valid); end
    step();
    n_cmp++; if (wb_valid !== 1'b1 || wb_tag !== 5'd2 || wb_data !== 32'hBF800000) begin
      n_err++; $display("FAIL ooo_fneg_wb: got %b/%0d/%h want 1/2/bf800000", wb_valid, wb_tag, wb_data); end
    step();
    n_cmp++; if (wb_valid !== 1'b1 || wb_tag !== 5'd1 || wb_data !== 32'h40000000) begin
      n_err++; $display("FAIL ooo_fadd_wb: got %b/%0d/%h want 1/1/40000000", wb_valid, wb_tag, wb_data); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] x2v [8];
    logic [31:0] exp [8];
    x2v = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    exp = '{32'h41700000, 32'h41600000, 32'h41500000, 32'h41400000,
            32'h41300000, 32'h41200000, 32'h41100000, 32'h41000000};
    for (int c = 0; c < 13; c++) begin
      if (c < 8) begin
        drive(2'b01, 5'(8 + c), 32'h41800000, x2v[c]);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want 1", c, in_ready); end
      end else begin
        idle();
      end
      if (c >= 4 && c <= 11) begin
        n_cmp++; if (wb_valid !== 1'b1 || wb_tag !== 5'(8 + c - 4) || wb_data !== exp[c-4]) begin
          n_err++; $display("FAIL b2b_wb[%0d]: got %b/%0d/%h want 1/%0d/%h", c, wb_valid, wb_tag, wb_data, 8 + c - 4, exp[c-4]); end
      end else if (c == 3 || c == 12) begin
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle[%0d]: got %b want 0", c, wb_valid); end
      end
      step();
    end
  endtask

  task automatic test_flush();
    drive(2'b00, 5'd6, 32'h3F800000, 32'h3F800000);
    step(); idle();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready_t1: got %b want 1", in_ready); end
    step();
    flush = 1'b1;
    drive(2'b11, 5'd7, 32'h3F800000, 32'h0);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready_t2: got %b want 0", in_ready); end
    step();
    flush = 1'b0; idle();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready_t3: got %b want 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy_t3: got %b want 0", busy); end
    step();
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL flush_wb_t4: got %b want 0", wb_valid); end
    step();
  endtask

  task automatic test_reset_mid();
    drive(2'b00, 5'd9,  32'h3F800000, 32'h3F800000); step();
    drive(2'b00, 5'd10, 32'h40000000, 32'h3F800000); step();
    drive(2'b00, 5'd11, 32'h40400000, 32'h3F800000); step();
    idle();
    #1 rstn = 1'b0;
    #1;
    n_cmp++; if (wb_valid !== 1'b0 || wb_tag !== 5'd0 || wb_data !== 32'd0) begin
      n_err++; $display("FAIL rmid_wb: got %b/%0d/%h want 0/0/0", wb_valid, wb_tag, wb_data); end
    n_cmp++; if (u_x1 !== 32'd0 || u_x2 !== 32'd0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL rmid_state: got ux1 %h ux2 %h busy %b rdy %b want 0", u_x1, u_x2, busy, in_ready); end
    @(posedge clk); #1;
    rstn = 1'b1;
    drive(2'b11, 5'd12, 32'h40000000, 32'h0);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_first_ready: got %b want 1", in_ready); end
    step(); idle();
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL rmid_r1: got %b want 0", wb_valid); end
    step();
    n_cmp++; if (wb_valid !== 1'b1 || wb_tag !== 5'd12 || wb_data !== 32'hC0000000) begin
      n_err++; $display("FAIL rmid_wb_r2: got %b/%0d/%h want 1/12/c0000000", wb_valid, wb_tag, wb_data); end
    step();
    n_cmp++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rmid_r3: got v%b busy%b want 0/0", wb_valid, busy); end
  endtask

  initial begin
    test_reset();
    test_fsub();
    test_collision();
    test_out_of_order();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
